// File: rtl/gt1_pkg.sv
// gt1_pkg: shared types and constants for the GT1 program loader.
package gt1_pkg;
    typedef logic [15:0] gt1_addr_t;
    typedef logic [8:0]  gt1_count_t;
    localparam int GT1_SIZE_ZERO_MEANS = 256;
    typedef enum logic [3:0] {
        ST_IDLE, ST_SEG_HI, ST_SEG_LO, ST_SEG_SIZE, ST_DATA,
        ST_WRITE, ST_EXEC_HI, ST_EXEC_LO, ST_DONE, ST_ERROR
    } gt1_state_t;
endpackage

// File: rtl/gt1_loader_ctrl.sv
// gt1_loader_ctrl: walks a GT1 image in the option ROM and writes its segments into RAM.
module gt1_loader_ctrl
    import gt1_pkg::*;
#(
    parameter int ROM_LAST_ADDR = 32767,
    parameter int ROM_BASE      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output gt1_addr_t   rom_addr,
    input  logic [7:0]  rom_data,
    output gt1_addr_t   ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we_req,
    input  logic        ram_we_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output gt1_addr_t   exec_addr
);
    gt1_state_t state_q, state_d;
    gt1_addr_t  rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d, exec_addr_q, exec_addr_d;
    gt1_count_t count_q, count_d;
    logic [7:0] hi_q, hi_d, lo_q, lo_d, ram_wdata_q, ram_wdata_d;
    logic       first_seg_q, first_seg_d, req_q, req_d;
    logic       consume, oob;

    assign consume = state_q inside {ST_SEG_HI, ST_SEG_LO, ST_SEG_SIZE, ST_DATA, ST_EXEC_HI, ST_EXEC_LO};
    assign oob     = rom_addr_q > 16'(ROM_LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        exec_addr_d = exec_addr_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        ram_wdata_d = ram_wdata_q;
        first_seg_d = first_seg_q;
        req_d       = req_q;
        // WRITE never consumes a byte, so an in-flight request finishes before the bounds trip
        if (consume && oob) begin
            state_d = ST_ERROR;
        end else begin
            if (consume) rom_addr_d = rom_addr_q + 16'd1;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
                    rom_addr_d  = 16'(ROM_BASE);
                    first_seg_d = 1'b1;
                    state_d     = ST_SEG_HI;
                end
                ST_SEG_HI: begin
                    hi_d    = rom_data;
                    state_d = (rom_data == 8'd0 && !first_seg_q) ? ST_EXEC_HI : ST_SEG_LO;
                end
                ST_SEG_LO: begin
                    lo_d    = rom_data;
                    state_d = ST_SEG_SIZE;
                end
                ST_SEG_SIZE: begin
                    count_d     = (rom_data == 8'd0) ? 9'(GT1_SIZE_ZERO_MEANS) : {1'b0, rom_data};
                    first_seg_d = 1'b0;
                    state_d     = ST_DATA;
                end
                ST_DATA: begin
                    ram_addr_d  = {hi_q, lo_q};
                    ram_wdata_d = rom_data;
                    req_d       = 1'b1;
                    state_d     = ST_WRITE;
                end
                ST_WRITE: if (ram_we_ack) begin
                    req_d   = 1'b0;
                    lo_d    = lo_q + 8'd1;
                    count_d = count_q - 9'd1;
                    state_d = (count_q == 9'd1) ? ST_SEG_HI : ST_DATA;
                end
                ST_EXEC_HI: begin
                    exec_addr_d[15:8] = rom_data;
                    state_d           = ST_EXEC_LO;
                end
                ST_EXEC_LO: begin
                    exec_addr_d[7:0] = rom_data;
                    state_d          = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= 16'(ROM_BASE);
            ram_addr_q  <= '0;
            exec_addr_q <= '0;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            ram_wdata_q <= '0;
            first_seg_q <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            exec_addr_q <= exec_addr_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ram_wdata_q <= ram_wdata_d;
            first_seg_q <= first_seg_d;
            req_q       <= req_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we_req = req_q;
    assign exec_addr  = exec_addr_q;
    assign done       = state_q == ST_DONE;
    assign error      = state_q == ST_ERROR;
    assign busy       = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
endmodule

// File: tb/tb_gt1_loader_ctrl.sv
// tb_gt1_loader_ctrl: directed GT1 load scenarios with a ROM model and an ack responder.
module tb_gt1_loader_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start_e = 1'b0;
    logic        ram_we_ack = 1'b0, ram_we_ack_e = 1'b1;
    logic [15:0] rom_addr, ram_addr, exec_addr, rom_addr_e, ram_addr_e, exec_addr_e;
    logic [7:0]  rom_data, ram_wdata, rom_data_e, ram_wdata_e;
    logic        ram_we_req, busy, done, error, ram_we_req_e, busy_e, done_e, error_e;
    logic [7:0]  rom [0:511];
    logic [15:0] wa [0:299];
    logic [7:0]  wd [0:299];
    logic [15:0] p_addr;
    logic [7:0]  p_data, last_e;
    int tests = 0, fails = 0, wr_n = 0, wr_e_n = 0, run = 0, max_run = 0, unstable = 0;
    int ack_delay = 0, wait_cnt = 0;

    always #5 clk = ~clk;

    assign rom_data   = (rom_addr < 16'd512) ? rom[rom_addr[8:0]] : 8'h00;
    assign rom_data_e = (rom_addr_e < 16'd512) ? rom[rom_addr_e[8:0]] : 8'h00;

    gt1_loader_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we_req(ram_we_req), .ram_we_ack(ram_we_ack),
        .busy(busy), .done(done), .error(error), .exec_addr(exec_addr)
    );

    gt1_loader_ctrl #(.ROM_LAST_ADDR(5), .ROM_BASE(0)) dut_e (
        .clk(clk), .reset(reset), .start(start_e), .rom_addr(rom_addr_e), .rom_data(rom_data_e),
        .ram_addr(ram_addr_e), .ram_wdata(ram_wdata_e), .ram_we_req(ram_we_req_e), .ram_we_ack(ram_we_ack_e),
        .busy(busy_e), .done(done_e), .error(error_e), .exec_addr(exec_addr_e)
    );

    // Ack responder and write monitor share one block so a write is logged exactly when req and ack meet
    always @(negedge clk) begin
        if (ack_delay == 0) ram_we_ack = 1'b1;
        else if (ram_we_req) begin
            ram_we_ack = wait_cnt >= ack_delay;
            wait_cnt++;
        end else begin
            ram_we_ack = 1'b0;
            wait_cnt = 0;
        end
        if (ram_we_req) begin
            run++;
            if (run > max_run) max_run = run;
            if (run > 1 && (ram_addr !== p_addr || ram_wdata !== p_data)) unstable++;
            p_addr = ram_addr;
            p_data = ram_wdata;
        end else run = 0;
        if (ram_we_req && ram_we_ack && wr_n < 300) begin
            wa[wr_n] = ram_addr;
            wd[wr_n] = ram_wdata;
            wr_n++;
        end
        if (ram_we_req_e) begin
            wr_e_n++;
            last_e = ram_wdata_e;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int base, input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) rom[base + i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 512; i++) rom[i] = 8'h00;
    endtask

    task automatic clr_mon();
        wr_n = 0; max_run = 0; unstable = 0; run = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done || error}, 32'd1);
    endtask

    initial begin
        clr_rom();
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_req", {31'd0, ram_we_req}, 0);
        check("rst_rom_addr", {16'd0, rom_addr}, 0);
        check("rst_exec", {16'd0, exec_addr}, 0);
        reset = 1'b0;

        put(0, 72'h02_00_03_AA_BB_CC_00_02_00, 9);
        clr_mon();
        pulse_start();
        check("t1_busy_after_start", {31'd0, busy}, 1);
        wait_end("t1_timeout", 100);
        check("t1_wr_n", wr_n, 3);
        check("t1_a0", {16'd0, wa[0]}, 32'h0200);
        check("t1_d0", {24'd0, wd[0]}, 32'hAA);
        check("t1_a1", {16'd0, wa[1]}, 32'h0201);
        check("t1_d1", {24'd0, wd[1]}, 32'hBB);
        check("t1_a2", {16'd0, wa[2]}, 32'h0202);
        check("t1_d2", {24'd0, wd[2]}, 32'hCC);
        check("t1_req_len", max_run, 1);
        check("t1_done", {31'd0, done}, 1);
        check("t1_error", {31'd0, error}, 0);
        check("t1_busy", {31'd0, busy}, 0);
        check("t1_exec", {16'd0, exec_addr}, 32'h0200);

        clr_rom();
        put(0, 80'h03_FE_04_11_22_33_44_00_03_FE, 10);
        clr_mon();
        pulse_start();
        check("t2_done_cleared", {31'd0, done}, 0);
        wait_end("t2_timeout", 100);
        check("t2_wr_n", wr_n, 4);
        check("t2_a0", {16'd0, wa[0]}, 32'h03FE);
        check("t2_a1", {16'd0, wa[1]}, 32'h03FF);
        check("t2_a2_wrap", {16'd0, wa[2]}, 32'h0300);
        check("t2_d2", {24'd0, wd[2]}, 32'h33);
        check("t2_a3", {16'd0, wa[3]}, 32'h0301);
        check("t2_d3", {24'd0, wd[3]}, 32'h44);
        check("t2_exec", {16'd0, exec_addr}, 32'h03FE);

        clr_rom();
        put(0, 24'h05_00_00, 3);
        for (int i = 0; i < 256; i++) rom[3 + i] = 8'(i);
        put(259, 56'h06_10_01_77_00_12_34, 7);
        clr_mon();
        pulse_start();
        wait_end("t3_timeout", 2000);
        check("t3_wr_n", wr_n, 257);
        check("t3_a0", {16'd0, wa[0]}, 32'h0500);
        check("t3_a255", {16'd0, wa[255]}, 32'h05FF);
        check("t3_d255", {24'd0, wd[255]}, 32'hFF);
        check("t3_a256", {16'd0, wa[256]}, 32'h0610);
        check("t3_d256", {24'd0, wd[256]}, 32'h77);
        check("t3_exec", {16'd0, exec_addr}, 32'h1234);

        clr_rom();
        put(0, 56'h00_30_01_5A_00_00_30, 7);
        clr_mon();
        pulse_start();
        wait_end("t4_timeout", 100);
        check("t4_wr_n", wr_n, 1);
        check("t4_a0", {16'd0, wa[0]}, 32'h0030);
        check("t4_d0", {24'd0, wd[0]}, 32'h5A);
        check("t4_done", {31'd0, done}, 1);
        check("t4_exec", {16'd0, exec_addr}, 32'h0030);

        clr_rom();
        put(0, 72'h02_00_03_AA_BB_CC_00_02_00, 9);
        ack_delay = 3;
        clr_mon();
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_end("t5_timeout", 200);
        check("t5_wr_n", wr_n, 3);
        check("t5_stable", unstable, 0);
        check("t5_req_len", max_run, 4);
        check("t5_a2", {16'd0, wa[2]}, 32'h0202);
        check("t5_d2", {24'd0, wd[2]}, 32'hCC);
        check("t5_exec", {16'd0, exec_addr}, 32'h0200);

        clr_rom();
        put(0, 64'h02_00_05_AA_BB_CC_DD_EE, 8);
        wr_e_n = 0;
        @(negedge clk) start_e = 1'b1;
        @(negedge clk) start_e = 1'b0;
        for (int n = 0; n < 100 && !error_e; n++) @(negedge clk);
        check("t6_error", {31'd0, error_e}, 1);
        check("t6_done", {31'd0, done_e}, 0);
        check("t6_busy", {31'd0, busy_e}, 0);
        check("t6_wr_n", wr_e_n, 3);
        check("t6_last_data", {24'd0, last_e}, 32'hCC);

        clr_rom();
        put(0, 72'h02_00_03_AA_BB_CC_00_02_00, 9);
        clr_mon();
        pulse_start();
        for (int n = 0; n < 50 && !ram_we_req; n++) @(negedge clk);
        check("t7_req_seen", {31'd0, ram_we_req}, 1);
        reset = 1'b1;
        #1;
        check("t7_req_dropped", {31'd0, ram_we_req}, 0);
        check("t7_busy", {31'd0, busy}, 0);
        check("t7_done", {31'd0, done}, 0);
        check("t7_rom_addr", {16'd0, rom_addr}, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("t7_idle_after", {31'd0, busy || done || error}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
